grid_scanner: RTL and testbench

Sweeps a GRID_X × GRID_Y field stored row-major in the simple dual-port grid RAM, starting at address 0. Drives the RAM read address and absorbs its fixed 1-cycle read latency. Emits each cell downstream as a valid/ready stream tagged with x/y coordinates and an end-of-sweep marker, at one cell per cycle when downstream never stalls. It is the fetch stage that sits directly downstream of the grid RAM read port and feeds the stencil/update pipeline.

---
 rtl/grid_pkg.sv | 25 ++
 rtl/scan_fifo.sv | 84 ++++++++
 rtl/grid_scanner.sv | 181 ++++++++++++++++++
 tb/tb_grid_scanner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and constants for the grid_scanner fetch stage.
// With STENCIL_BOUNDARY_EN defined, each cell tag also carries {N,S,W,E} edge flags.
package grid_pkg;

    localparam int SCAN_FIFO_DEPTH = 2;
    // Coordinates are stored at a fixed width; the top keeps only the low bits it needs.
    localparam int TAG_COORD_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [TAG_COORD_W-1:0] x;
        logic [TAG_COORD_W-1:0] y;
        logic                   last;
`ifdef STENCIL_BOUNDARY_EN
        logic [3:0]             boundary;
`endif
    } cell_tag_t;

endpackage

// File: rtl/scan_fifo.sv
// Two-entry registered FIFO holding ram_data plus its cell tag; entry 0 is always the head.
// The head stays put while not popped, so the stream is stable under backpressure.
module scan_fifo
    import grid_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  cell_tag_t             push_tag,
    output logic [DATA_WIDTH-1:0] head_data,
    output cell_tag_t             head_tag,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    cell_tag_t             tag0_q, tag0_d, tag1_q, tag1_d;
    logic [1:0]            count_q, count_d;

    // Next-state for the two entries and the occupancy counter.
    always_comb begin
        data0_d  = data0_q;
        data1_d  = data1_q;
        tag0_d   = tag0_q;
        tag1_d   = tag1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = push_data;
                    tag0_d  = push_tag;
                end else begin
                    data1_d = push_data;
                    tag1_d  = push_tag;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                tag0_d  = tag1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    data0_d = push_data;
                    tag0_d  = push_tag;
                end else begin
                    data0_d = data1_q;
                    tag0_d  = tag1_q;
                    data1_d = push_data;
                    tag1_d  = push_tag;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Entry and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0_q <= '0;
            data1_q <= '0;
            tag0_q  <= '0;
            tag1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
            count_q <= count_d;
        end
    end

    assign head_data = data0_q;
    assign head_tag  = tag0_q;
    assign count     = count_q;

endmodule

// File: rtl/grid_scanner.sv
// Row-major sweep of a GRID_X x GRID_Y grid RAM, streamed out as tagged valid/ready beats.
// Optional macro STENCIL_BOUNDARY_EN adds the out_boundary {N,S,W,E} port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 10
`endif
module grid_scanner
    import grid_pkg::*;
#(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int GRID_X        = 32,
    parameter int GRID_Y        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDRESS_WIDTH-1:0]   read_address,
    input  logic [DATA_WIDTH-1:0]      ram_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(GRID_X)-1:0]  out_x,
    output logic [$clog2(GRID_Y)-1:0]  out_y,
`ifdef STENCIL_BOUNDARY_EN
    output logic [3:0]                 out_boundary,
`endif
    output logic                       out_last
);

    localparam int XW = $clog2(GRID_X);
    localparam int YW = $clog2(GRID_Y);

    scan_state_t              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic                     inflight_q, inflight_d;
    cell_tag_t                tag_q, tag_d, issue_tag;
    logic                     busy_q, done_q;
    logic [1:0]               count;
    logic [2:0]               occupancy;
    logic                     pop, issue, x_at_end, y_at_end, addr_at_end;
    logic [DATA_WIDTH-1:0]    head_data;
    cell_tag_t                head_tag;

    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign occupancy   = {1'b0, count} + {2'b00, inflight_q};
    // out_ready reaches issue combinationally so a pop frees a slot in the same cycle.
    assign issue       = (state_q == SCAN) && (occupancy < (3'd2 + {2'b00, pop}));
    assign x_at_end    = (x_q == XW'(GRID_X - 1));
    assign y_at_end    = (y_q == YW'(GRID_Y - 1));
    assign addr_at_end = (addr_q == ADDRESS_WIDTH'(GRID_X * GRID_Y - 1));

    // Tag for the address being issued this cycle.
    always_comb begin
        issue_tag          = '0;
        issue_tag.x        = TAG_COORD_W'(x_q);
        issue_tag.y        = TAG_COORD_W'(y_q);
        issue_tag.last     = x_at_end && y_at_end;
`ifdef STENCIL_BOUNDARY_EN
        issue_tag.boundary = {(y_q == {YW{1'b0}}), y_at_end, (x_q == {XW{1'b0}}), x_at_end};
`endif
    end

    // Sweep FSM, address/coordinate counters and the one-deep in-flight tag.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        x_d        = x_q;
        y_d        = y_q;
        inflight_d = issue;
        if (issue) begin
            tag_d = issue_tag;
        end else begin
            tag_d = tag_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    addr_d  = {ADDRESS_WIDTH{1'b0}};
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (issue) begin
                    addr_d = addr_q + ADDRESS_WIDTH'(1);
                    if (x_at_end) begin
                        x_d = {XW{1'b0}};
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                        y_d = y_q;
                    end
                    if (addr_at_end) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            DRAIN: begin
                // Leave on the final handshake so done lands in the very next cycle.
                if (!inflight_q && (count == {1'b0, pop})) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= {ADDRESS_WIDTH{1'b0}};
            x_q        <= {XW{1'b0}};
            y_q        <= {YW{1'b0}};
            inflight_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            busy_q     <= (state_d == SCAN) || (state_d == DRAIN);
            done_q     <= (state_d == DONE);
        end
    end

    scan_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .pop       (pop),
        .push_data (ram_data),
        .push_tag  (tag_q),
        .head_data (head_data),
        .head_tag  (head_tag),
        .count     (count)
    );

    logic unused_tag_bits;
    assign unused_tag_bits = ^{head_tag.x[TAG_COORD_W-1:XW], head_tag.y[TAG_COORD_W-1:YW]};

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_address = addr_q;
    assign out_data     = head_data;
    assign out_x        = head_tag.x[XW-1:0];
    assign out_y        = head_tag.y[YW-1:0];
    assign out_last     = head_tag.last;
`ifdef STENCIL_BOUNDARY_EN
    assign out_boundary = head_tag.boundary;
`endif

endmodule

// File: tb/tb_grid_scanner.sv
// Self-checking bench for grid_scanner on a 4x3 grid whose RAM holds mem[a] = 3a.
module tb_grid_scanner;

    localparam int GX    = 4;
    localparam int GY    = 3;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int NCELL = GX * GY;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] read_address;
    logic [DW-1:0] ram_data = '0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_x, out_y;
`ifdef STENCIL_BOUNDARY_EN
    logic [3:0]    out_boundary;
`endif

    int nvec  = 0;
    int nfail = 0;

    // Model state: phase 0 idle, 1 sweeping, 2 done cycle; exp_idx = beats delivered.
    int   phase   = 0;
    int   exp_idx = 0;
    logic chk_en  = 1'b0;

    always #5 clk = ~clk;

    // Grid RAM with 1-cycle read latency, reading unconditionally.
    always @(posedge clk) ram_data <= DW'(3 * int'(read_address));

    grid_scanner #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .GRID_X        (GX),
        .GRID_Y        (GY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .read_address (read_address),
        .ram_data     (ram_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_x        (out_x),
        .out_y        (out_y),
`ifdef STENCIL_BOUNDARY_EN
        .out_boundary (out_boundary),
`endif
        .out_last     (out_last)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every cycle against the sweep model.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] held_data;
        logic [1:0]    held_x, held_y;
        logic          held_last;
        int            ex, ey;
        logic          hs;
        stall_prev = 1'b0;
        held_data  = '0;
        held_x     = '0;
        held_y     = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase      = 0;
                exp_idx    = 0;
                stall_prev = 1'b0;
            end else if (chk_en) begin
                chk("busy", int'(busy), int'(phase == 1));
                chk("done", int'(done), int'(phase == 2));
                if (phase != 1) chk("valid_when_not_busy", int'(out_valid), 0);
                if (phase == 1) chk("issue_lead_le_2", int'(int'(read_address) <= exp_idx + 2), 1);
                if (stall_prev) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), int'(held_data));
                    chk("hold_x", int'(out_x), int'(held_x));
                    chk("hold_y", int'(out_y), int'(held_y));
                    chk("hold_last", int'(out_last), int'(held_last));
                end
                hs = out_valid && out_ready;
                if (hs) begin
                    chk("beat_in_range", int'(exp_idx < NCELL), 1);
                    if (exp_idx < NCELL) begin
                        ex = exp_idx % GX;
                        ey = exp_idx / GX;
                        chk("beat_data", int'(out_data), 3 * exp_idx);
                        chk("beat_x", int'(out_x), ex);
                        chk("beat_y", int'(out_y), ey);
                        chk("beat_last", int'(out_last), int'(exp_idx == NCELL - 1));
`ifdef STENCIL_BOUNDARY_EN
                        chk("beat_boundary", int'(out_boundary),
                            int'({ey == 0, ey == GY - 1, ex == 0, ex == GX - 1}));
                        if (ex == 0 && ey == 0) chk("bnd_0_0", int'(out_boundary), int'(4'b1010));
                        if (ex == 3 && ey == 0) chk("bnd_3_0", int'(out_boundary), int'(4'b1001));
                        if (ex == 1 && ey == 1) chk("bnd_1_1", int'(out_boundary), int'(4'b0000));
                        if (ex == 0 && ey == 2) chk("bnd_0_2", int'(out_boundary), int'(4'b0110));
                        if (ex == 3 && ey == 2) chk("bnd_3_2", int'(out_boundary), int'(4'b0101));
`endif
                    end
                    exp_idx++;
                end
                stall_prev = out_valid && !out_ready;
                held_data  = out_data;
                held_x     = out_x;
                held_y     = out_y;
                held_last  = out_last;
                case (phase)
                    0: if (start) begin
                        phase   = 1;
                        exp_idx = 0;
                    end
                    1: if (hs && exp_idx == NCELL) phase = 2;
                    default: phase = 0;
                endcase
            end
        end
    end

    // mode 0 free-run, 1 backpressure, 2 repeated start, 3 mid-sweep reset.
    task automatic run_scn(input int mode);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (mode == 2 && c == 6) || (mode == 3 && c == 9);
            out_ready = !(mode == 1 && c >= 4 && c <= 9);
            rst       = (mode == 3 && c == 7);
            @(negedge clk);
            if (mode == 0 || mode == 2) begin
                if (c == 2) chk("first_valid_not_early", int'(out_valid), 0);
                if (c == 3) begin
                    chk("first_valid_c3", int'(out_valid), 1);
                    chk("first_data_c3", int'(out_data), 0);
                end
                if (c == 8) begin
                    chk("beat5_data", int'(out_data), 15);
                    chk("beat5_xy", int'({out_y, out_x}), int'(4'b0101));
                end
                if (c == 13) chk("last_not_early", int'(out_last), 0);
                if (c == 14) begin
                    chk("last_beat_flag", int'(out_last), 1);
                    chk("last_beat_data", int'(out_data), 33);
                end
                if (c == 15) begin
                    chk("done_c15", int'(done), 1);
                    chk("busy_low_c15", int'(busy), 0);
                end
                if (c == 16) chk("done_one_cycle", int'(done), 0);
            end
            if (mode == 1) begin
                if (c >= 4 && c <= 9) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_data", int'(out_data), 3);
                    chk("stall_x", int'(out_x), 1);
                    chk("stall_addr_le_3", int'(int'(read_address) <= 3), 1);
                end
                if (c == 21) chk("bp_done_c21", int'(done), 1);
            end
            if (mode == 3) begin
                if (c == 7) begin
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_valid", int'(out_valid), 0);
                    chk("rst_addr", int'(read_address), 0);
                end
                if (c == 11) chk("restart_not_early", int'(out_valid), 0);
                if (c == 12) begin
                    chk("restart_valid_c12", int'(out_valid), 1);
                    chk("restart_data_c12", int'(out_data), 0);
                end
                if (c == 24) chk("restart_done_c24", int'(done), 1);
            end
        end
        start = 1'b0;
        chk("scn_beats_total", exp_idx, NCELL);
        chk("scn_ends_idle", phase, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_addr", int'(read_address), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_xy_last", int'({out_x, out_y, out_last}), 0);
`ifdef STENCIL_BOUNDARY_EN
        chk("reset_boundary", int'(out_boundary), 0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        run_scn(0);
        run_scn(1);
        run_scn(2);
        run_scn(3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
